regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file for the single-cycle RISC-V core and its successors.

---
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a hardware clear sweep, busy/done handshake and write-drop flag.
// Define REGFILE_BYPASS_EN to forward a same-cycle legal write to matching read ports.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done,
    input  logic                wr_en,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    output logic                wr_drop,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;
    localparam logic [AW-1:0] FIRST    = (ZERO_REG != 0) ? AW'(1) : AW'(0);
    localparam logic [AW-1:0] LAST     = AW'(NREGS - 1);
    localparam logic [AW:0]   NREGS_W  = (AW + 1)'(NREGS);

    logic [0:0]      state;
    logic [AW-1:0]   clr_cnt;
    logic [XLEN-1:0] mem [NREGS];
    logic            waddr_ok;
    logic            wr_ok;
    logic            wr_commit;

    assign clr_busy  = (state == ST_CLEAR);
    assign waddr_ok  = ({1'b0, waddr} < NREGS_W);
    assign wr_ok     = wr_en && (state == ST_IDLE) && waddr_ok;
    // Entry 0 swallows writes silently when hardwired to zero; that is not a drop.
    assign wr_commit = wr_ok && !((ZERO_REG != 0) && (waddr == '0));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CLEAR;
            clr_cnt  <= FIRST;
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            wr_drop  <= wr_en && ((state == ST_CLEAR) || !waddr_ok);
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= FIRST;
                    end
                end
                default: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST) begin
                        state    <= ST_IDLE;
                        clr_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: the array has no reset branch; the clear sweep initialises it and reads are masked until then.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_commit) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            ra_ok;
        logic            zero_hit;
        logic            byp;
        logic [XLEN-1:0] stored;

        assign ra       = raddr[k*AW +: AW];
        assign ra_ok    = ({1'b0, ra} < NREGS_W);
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);
        assign stored   = ra_ok ? mem[ra] : '0;
`ifdef REGFILE_BYPASS_EN
        assign byp      = wr_ok && (ra == waddr);
`else
        assign byp      = 1'b0;
`endif
        // Busy and zero-register masking win over the bypass path.
        assign rdata[k*XLEN +: XLEN] = (clr_busy || zero_hit || !ra_ok) ? '0 :
                                       byp ? wdata : stored;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default instance plus an NREGS=24/NRD=3/ZERO_REG=0 instance,
// directed scenarios and randomized traffic against an array-based reference model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wr_en_v;
    logic [1:0]  clr_req_v;
    logic [4:0]  waddr_v [2];
    logic [31:0] wdata_v [2];
    logic [4:0]  raddr_v [2][3];
    logic [1:0]  busy_w;
    logic [1:0]  done_w;
    logic [1:0]  drop_w;
    logic [9:0]  raddr_a;
    logic [14:0] raddr_b;
    logic [63:0] rdata_a;
    logic [95:0] rdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_mem [2][32];
    bit          m_busy [2];
    bit          m_done [2];
    bit          m_drop [2];
    int          m_left [2];

    always #5 clk = ~clk;

    assign raddr_a = {raddr_v[0][1], raddr_v[0][0]};
    assign raddr_b = {raddr_v[1][2], raddr_v[1][1], raddr_v[1][0]};

    regfile_mp dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req_v[0]),
        .clr_busy (busy_w[0]),
        .clr_done (done_w[0]),
        .wr_en    (wr_en_v[0]),
        .waddr    (waddr_v[0]),
        .wdata    (wdata_v[0]),
        .wr_drop  (drop_w[0]),
        .raddr    (raddr_a),
        .rdata    (rdata_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(24), .NRD(3), .ZERO_REG(0)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req_v[1]),
        .clr_busy (busy_w[1]),
        .clr_done (done_w[1]),
        .wr_en    (wr_en_v[1]),
        .waddr    (waddr_v[1]),
        .wdata    (wdata_v[1]),
        .wr_drop  (drop_w[1]),
        .raddr    (raddr_b),
        .rdata    (rdata_b)
    );

    function automatic int nregs(int i);
        return (i == 0) ? 32 : 24;
    endfunction

    function automatic bit zr(int i);
        return (i == 0);
    endfunction

    function automatic int nports(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic logic [31:0] rd_obs(int i, int p);
        return (i == 0) ? rdata_a[p*32 +: 32] : rdata_b[p*32 +: 32];
    endfunction

    function automatic logic [31:0] m_read(int i, logic [4:0] a);
        if (m_busy[i]) return 32'h0;
        if (zr(i) && a == 5'd0) return 32'h0;
        if (int'(a) >= nregs(i)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en_v[i] && a == waddr_v[i]) return wdata_v[i];
`endif
        return m_mem[i][a];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b1;
            m_done[i] = 1'b0;
            m_drop[i] = 1'b0;
            m_left[i] = nregs(i) - (zr(i) ? 1 : 0);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit in_range;
            in_range  = int'(waddr_v[i]) < nregs(i);
            m_drop[i] = wr_en_v[i] && (m_busy[i] || !in_range);
            m_done[i] = 1'b0;
            if (m_busy[i]) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                    for (int j = 0; j < 32; j++) m_mem[i][j] = 32'h0;
                end
            end else begin
                if (wr_en_v[i] && in_range && !(zr(i) && waddr_v[i] == 5'd0))
                    m_mem[i][waddr_v[i]] = wdata_v[i];
                if (clr_req_v[i]) begin
                    m_busy[i] = 1'b1;
                    m_left[i] = nregs(i) - (zr(i) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic check_reads();
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < nports(i); p++)
                check($sformatf("rd i%0d p%0d a%0d", i, p, raddr_v[i][p]),
                      rd_obs(i, p), m_read(i, raddr_v[i][p]));
    endtask

    task automatic check_regs();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("busy i%0d", i), {31'h0, busy_w[i]}, {31'h0, m_busy[i]});
            check($sformatf("done i%0d", i), {31'h0, done_w[i]}, {31'h0, m_done[i]});
            check($sformatf("drop i%0d", i), {31'h0, drop_w[i]}, {31'h0, m_drop[i]});
        end
    endtask

    task automatic idle();
        wr_en_v   = '0;
        clr_req_v = '0;
        for (int i = 0; i < 2; i++) begin
            waddr_v[i] = '0;
            wdata_v[i] = '0;
            for (int p = 0; p < 3; p++) raddr_v[i][p] = '0;
        end
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic cycle();
        #1;
        check_reads();
        model_step();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs();
        check_reads();
        repeat (ncyc) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
        idle();
        wr_en_v[0] = 1'b1;
        waddr_v[0] = a;
        wdata_v[0] = d;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        idle();
        @(posedge clk);
        #1;

        // Reset held three cycles, then the automatic sweep must take 31 cycles.
        do_reset(3);
        n = 0;
        while (busy_w[0] && n < 100) begin
            cycle();
            n++;
        end
        check("t1 sweep_len", n, 31);
        check("t1 done", {31'h0, done_w[0]}, 32'h1);
        for (int a = 0; a < 32; a += 2) begin
            idle();
            raddr_v[0][0] = 5'(a);
            raddr_v[0][1] = 5'(a + 1);
            #1;
            check($sformatf("t1 zero x%0d", a), rdata_a[31:0], 32'h0);
            check($sformatf("t1 zero x%0d", a + 1), rdata_a[63:32], 32'h0);
            cycle();
        end

        // Basic write then dual-port read; entry 0 stays zero without a drop.
        wr_a(5'd5, 32'hDEADBEEF);
        idle();
        raddr_v[0][0] = 5'd5;
        raddr_v[0][1] = 5'd5;
        #1;
        check("t2 p0", rdata_a[31:0], 32'hDEADBEEF);
        check("t2 p1", rdata_a[63:32], 32'hDEADBEEF);
        cycle();
        wr_a(5'd0, 32'h1234);
        check("t2 x0 drop", {31'h0, drop_w[0]}, 32'h0);
        idle();
        #1;
        check("t2 x0", rdata_a[31:0], 32'h0);
        cycle();

        // Same-cycle write/read of x7.
        wr_a(5'd7, 32'h0000_0777);
        idle();
        wr_en_v[0]    = 1'b1;
        waddr_v[0]    = 5'd7;
        wdata_v[0]    = 32'hA5A5A5A5;
        raddr_v[0][0] = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("t3 bypass", rdata_a[31:0], 32'hA5A5A5A5);
`else
        check("t3 old", rdata_a[31:0], 32'h0000_0777);
`endif
        cycle();
        idle();
        raddr_v[0][0] = 5'd7;
        #1;
        check("t3 next", rdata_a[31:0], 32'hA5A5A5A5);
        cycle();

        // Second instance: x0 is ordinary, x23 is the top entry, x30 is out of range.
        idle();
        wr_en_v[1] = 1'b1; waddr_v[1] = 5'd0; wdata_v[1] = 32'd1;
        cycle();
        check("t6 x0 drop", {31'h0, drop_w[1]}, 32'h0);
        wr_en_v[1] = 1'b1; waddr_v[1] = 5'd23; wdata_v[1] = 32'd2;
        cycle();
        wr_en_v[1] = 1'b1; waddr_v[1] = 5'd30; wdata_v[1] = 32'd3;
        cycle();
        check("t6 x30 drop", {31'h0, drop_w[1]}, 32'h1);
        idle();
        raddr_v[1][0] = 5'd0;
        raddr_v[1][1] = 5'd23;
        raddr_v[1][2] = 5'd30;
        #1;
        check("t6 x0", rdata_b[31:0], 32'd1);
        check("t6 x23", rdata_b[63:32], 32'd2);
        check("t6 x30", rdata_b[95:64], 32'd0);
        cycle();

        // Fill, then clear with a dropped write and an ignored second request.
        for (int a = 1; a < 32; a++) wr_a(5'(a), 32'(a * 3));
        idle();
        raddr_v[0][0] = 5'd10;
        raddr_v[0][1] = 5'd31;
        #1;
        check("t4 x10", rdata_a[31:0], 32'd30);
        check("t4 x31", rdata_a[63:32], 32'd93);
        clr_req_v[0] = 1'b1;
        cycle();
        n = 0;
        while (busy_w[0] && n < 100) begin
            idle();
            if (n == 0) begin
                wr_en_v[0] = 1'b1;
                waddr_v[0] = 5'd9;
                wdata_v[0] = 32'hFFFF_0009;
            end
            if (n == 5) clr_req_v[0] = 1'b1;
            cycle();
            if (n == 0) check("t4 drop", {31'h0, drop_w[0]}, 32'h1);
            n++;
        end
        check("t4 busy_len", n, 31);
        check("t4 done", {31'h0, done_w[0]}, 32'h1);
        for (int a = 0; a < 32; a += 2) begin
            idle();
            raddr_v[0][0] = 5'(a);
            raddr_v[0][1] = 5'(a + 1);
            #1;
            check($sformatf("t4 clr x%0d", a), rdata_a[31:0], 32'h0);
            check($sformatf("t4 clr x%0d", a + 1), rdata_a[63:32], 32'h0);
            cycle();
        end

        // Reset ten cycles into a sweep: the sweep restarts and completes exactly once.
        pulses = 0;
        idle();
        clr_req_v[0] = 1'b1;
        cycle();
        idle();
        repeat (10) begin
            cycle();
            if (done_w[0]) pulses++;
        end
        do_reset(2);
        n = 0;
        while (busy_w[0] && n < 100) begin
            cycle();
            if (done_w[0]) pulses++;
            n++;
        end
        check("t5 busy_len", n, 31);
        repeat (3) begin
            cycle();
            if (done_w[0]) pulses++;
        end
        check("t5 done_pulses", pulses, 1);

        // Randomized traffic on both instances against the model.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                wr_en_v[i]   = ($urandom_range(0, 1) == 1);
                clr_req_v[i] = ($urandom_range(0, 79) == 0);
                waddr_v[i]   = 5'($urandom_range(0, 31));
                wdata_v[i]   = $urandom;
                for (int p = 0; p < 3; p++)
                    raddr_v[i][p] = ($urandom_range(0, 3) == 0) ? waddr_v[i]
                                                               : 5'($urandom_range(0, 31));
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
